enc_1_act: RTL and testbench
============================

# enc_1_act

Element-wise activation stage that sits directly downstream of the first encoder layer. It snapshots the 6-element fixed-point vector produced by the encoder layer and applies a piecewise-linear (PLAN) sigmoid to one element per cycle through a 2-stage pipeline. It then presents all six activated values at once with a one-cycle `done` pulse, so the next layer sees a stable vector.

## Interface
- `BITSIZE`, default 20: width of one element, signed two's complement, 12 fractional bits (1.0 = 4096).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to process `x`; sampled on `clk`, accepted only when `busy`=0.
- `x`  input  BITSIZE*6  pre-activation vector; element k is at `x[BITSIZE*k +: BITSIZE]`.
- `y`  output  BITSIZE*6  activated vector, same packing; reset value 0.
- `busy`  output  1  high from the accepting edge until the commit edge; reset value 0.
- `done`  output  1  single-cycle pulse when `y` is committed; reset value 0.
- `ovf`  output  1  exists only with `ENC_ACT_OVF_EN`; sticky saturation flag; reset value 0.

## Operation
- States: IDLE and RUN, plus a 3-bit element index `k` (0..5) and a stage-2 valid bit.
- IDLE, `start`=1: capture `x` into a snapshot register, set `busy`, `k`<=0, go to RUN. `x` may change afterwards.
- Stage 1, one element per edge while RUN: register sign, magnitude `m`=|x_k| and segment.
  - If x_k = -2^(BITSIZE-1), force `m` to full scale, which lands in segment 3.
- Stage 2: compute `p` from `m` and segment, then apply sign. All shifts are logical right shifts of `m` with truncation; no rounding.
  - Segment 3, `m` >= 20480 (5.0): `p` = 4096.
  - Segment 2, 9728 <= `m` < 20480: `p` = (`m`>>5) + 3456.
  - Segment 1, 4096 <= `m` < 9728: `p` = (`m`>>3) + 2560.
  - Segment 0, `m` < 4096: `p` = (`m`>>2) + 2048.
  - Result is `p` for non-negative x_k and 4096 - `p` for negative x_k. It always lies in [0, 4096], so no output saturation is needed.
- Stage-2 results for elements 0..4 go into a work buffer. Element 5 and the buffer are committed to `y` together on one edge. `y` never shows a partial vector.
- After commit: `busy`<=0, `done`<=1 for one cycle, return to IDLE.
- `start` while `busy`=1 is ignored, including on the commit edge.
- `reset` at any time clears the snapshot, work buffer, `y`, `busy`, `done`, `ovf`, `k` and valid bits, and returns to IDLE. An aborted run never commits.

## Timing
- Accept edge E0 (`start`=1, `busy`=0).
- Stage 1 handles elements 0..5 at edges E1..E6.
- Stage 2 writes elements 0..4 at E2..E6; element 5 and the `y` commit occur at E7.
- `busy` is high after E0 through E7. `done` is high in the cycle after E7 only.
- Latency is 7 edges from accept to commit. Earliest next accept is E8; `start` held high continuously restarts every 8 cycles.
- `y` is held constant between commits.

## Configuration
- `ENC_ACT_OVF_EN` defined:
  - Port `ovf` exists.
  - `ovf` is set on the stage-1 edge of any element with `m` >= 20480.
  - `ovf` is cleared on reset and on an accepted `start`. A new run therefore reports only its own saturation.
  - Setting and clearing happen on different edges, so they never coincide.
- `ENC_ACT_OVF_EN` undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Test plan
- Reset, then `x` all 0 and `start` pulse: `done` is observed exactly 8 cycles after the `start` cycle, and every `y` element = 2048 (0x00800).
- `x` = {4096, -4096, 8192, 9728, 20480, 0x80000}, `start`: `y` = {3072, 1024, 3584, 3760, 4096, 0}. With `ENC_ACT_OVF_EN`, `ovf`=1.
- Change `x` at E1 and pulse `start` at E3 and at E7: the result reflects the E0 snapshot, exactly one `done` pulse occurs, and `busy` falls after E7.
- Hold `start` high for 30 cycles with `x` all 2048: `done` pulses every 8 cycles, and each `y` element = 2560.
- Assert `reset` at E4 mid-run: `y`=0, `busy`=0, `done`=0 and `ovf`=0 immediately, and no `done` appears later. A subsequent `start` completes normally.
- Run with `x` all 30000 (`ovf`=1), then run with `x` all 0: `ovf` clears on the accepting edge and stays 0 through the run. `y` = 2048 after the second run.

Source files
------------

// File: rtl/enc_1_act_if.sv
//==============================================================================
// Module      : enc_1_act_if
// Description : Start/vector handshake bundle between an encoder layer and the
//               enc_1_act activation stage. ovf exists only with ENC_ACT_OVF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface enc_1_act_if #(
  parameter int BITSIZE = 20
);
  logic                   start;
  logic [BITSIZE*6-1:0]   x;
  logic [BITSIZE*6-1:0]   y;
  logic                   busy;
  logic                   done;
`ifdef ENC_ACT_OVF_EN
  logic                   ovf;

  modport master (output start, output x, input y, input busy, input done, input ovf);
  modport slave  (input start, input x, output y, output busy, output done, output ovf);
`else
  modport master (output start, output x, input y, input busy, input done);
  modport slave  (input start, input x, output y, output busy, output done);
`endif
endinterface

`default_nettype wire

// File: rtl/enc_1_act.sv
//==============================================================================
// Module      : enc_1_act
// Description : PLAN sigmoid over a 6-element fixed-point vector (12 fractional
//               bits), one element per cycle through a 2-stage pipeline, with
//               an atomic commit of the full vector and a one-cycle done pulse.
//               Optional sticky saturation flag: define ENC_ACT_OVF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module enc_1_act #(
  parameter int BITSIZE = 20
) (
  input  wire logic   clk,
  input  wire logic   reset,
  enc_1_act_if.slave  bus
);

  localparam int N_ELEM = 6;

  localparam logic [BITSIZE-1:0] c_one       = BITSIZE'(4096);
  localparam logic [BITSIZE-1:0] c_seg1_min  = BITSIZE'(4096);
  localparam logic [BITSIZE-1:0] c_seg2_min  = BITSIZE'(9728);
  localparam logic [BITSIZE-1:0] c_seg3_min  = BITSIZE'(20480);
  localparam logic [BITSIZE-1:0] c_seg0_off  = BITSIZE'(2048);
  localparam logic [BITSIZE-1:0] c_seg1_off  = BITSIZE'(2560);
  localparam logic [BITSIZE-1:0] c_seg2_off  = BITSIZE'(3456);
  localparam logic [BITSIZE-1:0] c_most_neg  = {1'b1, {(BITSIZE-1){1'b0}}};
  localparam logic [BITSIZE-1:0] c_full_mag  = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic [2:0]         c_last_idx  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_accept;
  logic                   w_commit;

  logic [BITSIZE*6-1:0]   r_snap;
  logic [2:0]             r_k;
  logic                   r_issue;

  logic                   r_s1_valid;
  logic [2:0]             r_s1_idx;
  logic                   r_s1_neg;
  logic [BITSIZE-1:0]     r_s1_mag;
  logic [1:0]             r_s1_seg;

  logic [BITSIZE-1:0]     r_buf [N_ELEM-1];
  logic [BITSIZE*6-1:0]   r_y;
  logic                   r_done;

  logic [BITSIZE-1:0]     w_elems [N_ELEM];
  logic [BITSIZE-1:0]     w_elem;
  logic                   w_neg;
  logic [BITSIZE-1:0]     w_mag;
  logic [1:0]             w_seg;
  logic [BITSIZE-1:0]     w_p;
  logic [BITSIZE-1:0]     w_res;

  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_unpack
      assign w_elems[gi] = r_snap[BITSIZE*gi +: BITSIZE];
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Control FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = r_s1_valid && (r_s1_idx == c_last_idx);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_commit) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Stage 1: sign, magnitude and segment of the selected snapshot element
  //--------------------------------------------------------------------------
  always_comb begin
    w_elem = w_elems[r_k];
    w_neg  = w_elem[BITSIZE-1];
    // The most negative value has no positive counterpart; pin it to full scale.
    if (w_elem == c_most_neg) begin
      w_mag = c_full_mag;
    end else if (w_neg) begin
      w_mag = -w_elem;
    end else begin
      w_mag = w_elem;
    end
    if (w_mag >= c_seg3_min) begin
      w_seg = 2'd3;
    end else if (w_mag >= c_seg2_min) begin
      w_seg = 2'd2;
    end else if (w_mag >= c_seg1_min) begin
      w_seg = 2'd1;
    end else begin
      w_seg = 2'd0;
    end
  end

  //--------------------------------------------------------------------------
  // Stage 2: piecewise-linear sigmoid, mirrored about 0.5 for negative inputs
  //--------------------------------------------------------------------------
  always_comb begin
    case (r_s1_seg)
      2'd3:    w_p = c_one;
      2'd2:    w_p = (r_s1_mag >> 5) + c_seg2_off;
      2'd1:    w_p = (r_s1_mag >> 3) + c_seg1_off;
      default: w_p = (r_s1_mag >> 2) + c_seg0_off;
    endcase
    w_res = r_s1_neg ? (c_one - w_p) : w_p;
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap     <= '0;
      r_k        <= '0;
      r_issue    <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_neg   <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_seg   <= '0;
      for (int i = 0; i < N_ELEM-1; i++) begin
        r_buf[i] <= '0;
      end
      r_y        <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_commit;

      if (w_accept) begin
        r_snap  <= bus.x;
        r_k     <= '0;
        r_issue <= 1'b1;
      end else if (r_issue) begin
        if (r_k == c_last_idx) begin
          r_k     <= '0;
          r_issue <= 1'b0;
        end else begin
          r_k <= r_k + 3'd1;
        end
      end

      r_s1_valid <= r_issue;
      if (r_issue) begin
        r_s1_idx <= r_k;
        r_s1_neg <= w_neg;
        r_s1_mag <= w_mag;
        r_s1_seg <= w_seg;
      end

      // Last element and the buffered ones land in y on the same edge.
      if (w_commit) begin
        for (int i = 0; i < N_ELEM-1; i++) begin
          r_y[BITSIZE*i +: BITSIZE] <= r_buf[i];
        end
        r_y[BITSIZE*(N_ELEM-1) +: BITSIZE] <= w_res;
      end else if (r_s1_valid) begin
        r_buf[r_s1_idx] <= w_res;
      end
    end
  end

`ifdef ENC_ACT_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (r_issue && (w_mag >= c_seg3_min)) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.y    = r_y;
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_enc_1_act.sv
//==============================================================================
// Module      : tb_enc_1_act
// Description : Self-checking bench for enc_1_act against an arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_enc_1_act;

  localparam int BITSIZE = 20;
  localparam int N       = 6;

  typedef logic [BITSIZE*N-1:0] vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  enc_1_act_if #(.BITSIZE(BITSIZE)) bus_if ();

  enc_1_act #(.BITSIZE(BITSIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic longint act_ref(input logic [BITSIZE-1:0] e);
    longint v = longint'(signed'(e));
    longint m = (v < 0) ? -v : v;
    longint p;
    if (m >= 20480)     p = 4096;
    else if (m >= 9728) p = m / 32 + 3456;
    else if (m >= 4096) p = m / 8 + 2560;
    else                p = m / 4 + 2048;
    return (v < 0) ? 4096 - p : p;
  endfunction

  function automatic logic sat_ref(input vec_t v);
    logic s = 1'b0;
    for (int k = 0; k < N; k++) begin
      longint e = longint'(signed'(v[BITSIZE*k +: BITSIZE]));
      if (e >= 20480 || e <= -20480) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [BITSIZE-1:0] rand_elem();
    int b [8] = '{0, 4095, 4096, 9727, 9728, 20479, 20480, 2048};
    int val;
    case ($urandom_range(0, 3))
      0: val = int'($urandom);
      1: begin
        val = b[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1) val = -val;
      end
      2: val = int'($urandom_range(0, 50000)) - 25000;
      default: val = -(1 << (BITSIZE-1));
    endcase
    return BITSIZE'(val);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < N; k++) v[BITSIZE*k +: BITSIZE] = rand_elem();
    return v;
  endfunction

  function automatic vec_t fill_vec(input int val);
    vec_t v;
    for (int k = 0; k < N; k++) v[BITSIZE*k +: BITSIZE] = BITSIZE'(val);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_y(input string tag, input vec_t src);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_y%0d", tag, k), 64'(bus_if.y[BITSIZE*k +: BITSIZE]),
            64'(act_ref(src[BITSIZE*k +: BITSIZE])));
    end
  endtask

  // Accept at E0, then expect done visible after E7 and y matching the model.
  task automatic run_vec(input string tag, input vec_t v);
    int   n = 0;
    logic ovf_seen = 1'b0;
    bus_if.x     = v;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
`ifdef ENC_ACT_OVF_EN
    check({tag, "_ovf_clr"}, 64'(bus_if.ovf), 64'd0);
`endif
    while (bus_if.done !== 1'b1 && n < 20) begin
      tick();
      n++;
`ifdef ENC_ACT_OVF_EN
      if (bus_if.ovf === 1'b1) ovf_seen = 1'b1;
`endif
    end
    check({tag, "_latency"}, 64'(n), 64'd7);
    check({tag, "_busy_end"}, 64'(bus_if.busy), 64'd0);
    check_y(tag, v);
`ifdef ENC_ACT_OVF_EN
    check({tag, "_ovf"}, 64'(bus_if.ovf), 64'(sat_ref(v)));
    check({tag, "_ovf_seen"}, 64'(ovf_seen), 64'(sat_ref(v)));
`endif
    tick();
    check({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va;
    vec_t vb;
    vec_t vd;
    int   dcnt;
    int   last;
    int   n;
    int   dir [6] = '{4096, -4096, 8192, 9728, 20480, -(1 << (BITSIZE-1))};

    bus_if.start = 1'b0;
    bus_if.x     = '0;
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_y%0d", k), 64'(bus_if.y[BITSIZE*k +: BITSIZE]), 64'd0);
    end
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
`ifdef ENC_ACT_OVF_EN
    check("rst_ovf", 64'(bus_if.ovf), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();

    // All-zero vector: every output is 0.5
    run_vec("zero", '0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("zero_abs%0d", k), 64'(bus_if.y[BITSIZE*k +: BITSIZE]), 64'd2048);
    end

    // Directed segment boundaries and the most negative value
    for (int k = 0; k < N; k++) vd[BITSIZE*k +: BITSIZE] = BITSIZE'(dir[k]);
    run_vec("dir", vd);

    // Snapshot isolation and ignored start while busy
    va = rand_vec();
    vb = rand_vec();
    bus_if.x     = va;
    bus_if.start = 1'b1;
    tick();
    dcnt = 0;
    for (int e = 1; e <= 11; e++) begin
      bus_if.x     = vb;
      bus_if.start = (e == 3 || e == 7);
      tick();
      if (e == 6) check("snap_busy_e6", 64'(bus_if.busy), 64'd1);
      if (e == 7) check("snap_busy_e7", 64'(bus_if.busy), 64'd0);
      if (bus_if.done === 1'b1) begin
        dcnt++;
        check("snap_done_edge", 64'(e), 64'd7);
        check_y("snap", va);
      end
    end
    bus_if.start = 1'b0;
    check("snap_done_count", 64'(dcnt), 64'd1);
    check("snap_idle", 64'(bus_if.busy), 64'd0);

    // Continuous start: restart every 8 cycles
    bus_if.x     = fill_vec(2048);
    bus_if.start = 1'b1;
    dcnt = 0;
    last = -1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus_if.done === 1'b1) begin
        dcnt++;
        check("hold_period", 64'(t - last), (last < 0) ? 64'(t + 1) : 64'd8);
        if (last < 0) check("hold_first", 64'(t), 64'd7);
        check_y("hold", fill_vec(2048));
        last = t;
      end
    end
    bus_if.start = 1'b0;
    check("hold_done_count", 64'(dcnt), 64'd3);
    n = 0;
    while (bus_if.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("hold_tail_latency", 64'(n), 64'd2);
    check_y("hold_tail", fill_vec(2048));
    tick();

    // Reset in the middle of a run
    bus_if.x     = rand_vec();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    reset = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("abort_y%0d", k), 64'(bus_if.y[BITSIZE*k +: BITSIZE]), 64'd0);
    end
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_done", 64'(bus_if.done), 64'd0);
`ifdef ENC_ACT_OVF_EN
    check("abort_ovf", 64'(bus_if.ovf), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (bus_if.done === 1'b1) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    run_vec("after_abort", rand_vec());

    // Saturating run followed by a clean one
    run_vec("sat", fill_vec(30000));
    run_vec("clean", '0);

    // Randomized vectors
    for (int r = 0; r < 12; r++) begin
      run_vec($sformatf("rand%0d", r), rand_vec());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
